// File: rtl/capture_pkg.sv
// Shared definitions for the capture sample-RAM sequencer: default address width,
// readout state encoding and the post-trigger count clamp.
package capture_pkg;

    localparam int ADDR_W_DEF = 10;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_e;

    // A requested post-trigger count of zero still captures the trigger sample.
    function automatic int unsigned clamp_one(input int unsigned n);
        return (n == 32'd0) ? 32'd1 : n;
    endfunction

endpackage

// File: rtl/capture_readout_seq.sv
// Readout sequencer: walks the sample RAM from the oldest to the newest sample
// of a completed capture, one address per rd_next.
module capture_readout_seq
    import capture_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              idle_i,
    input  logic              capture_valid_i,
    input  logic              wrapped_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic              rd_start_i,
    input  logic              rd_next_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              rd_busy_o,
    output logic              rd_last_o
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= RD_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            RD_IDLE: begin
                if (rd_start_i && idle_i && capture_valid_i) begin
                    state_d = RD_RUN;
                    // Once wrapped, the oldest sample sits at the write pointer.
                    addr_d  = wrapped_i ? wr_addr_i : '0;
                    rem_d   = wrapped_i ? '1 : (wr_addr_i - ONE);
                end
            end
            RD_RUN: begin
                if (rd_next_i) begin
                    if (rem_q == '0) begin
                        state_d = RD_IDLE;
                    end else begin
                        addr_d = addr_q + ONE;
                        rem_d  = rem_q - ONE;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
        if (start_i) begin
            state_d = RD_IDLE;
            addr_d  = addr_q;
            rem_d   = rem_q;
        end
    end

    assign rd_addr_o = addr_q;
    assign rd_busy_o = (state_q == RD_RUN);
    assign rd_last_o = (state_q == RD_RUN) && (rem_q == '0);

endmodule

// File: rtl/capture_buffer_ctrl.sv
// Sample-RAM sequencer for the logic capture peripheral: circular write pointer,
// post-trigger quota counting, trigger/wrap bookkeeping and ordered readout.
module capture_buffer_ctrl
    import capture_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              idle_i,
    input  logic              pre_trigger_i,
    input  logic              post_trigger_i,
    input  logic              sample_valid_i,
    input  logic [ADDR_W-1:0] post_count_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              complete_o,
    output logic [ADDR_W-1:0] trig_addr_o,
    output logic              wrapped_o,
    output logic              capture_valid_o,
    input  logic              rd_start_i,
    input  logic              rd_next_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              rd_busy_o,
    output logic              rd_last_o
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic              start_acc;
    logic              wr_en;
    logic              last_post_wr;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] n_q, n_d;
    logic              wrapped_q, wrapped_d;
    logic              done_q, done_d;
    logic              complete_q, complete_d;
    logic              cap_valid_q, cap_valid_d;
    logic              post_prev_q;

    assign start_acc = start_i & idle_i;
    // done_q blocks the stray sample the FSM may still present after complete.
    assign wr_en        = sample_valid_i & (pre_trigger_i | post_trigger_i) & ~done_q;
    assign last_post_wr = wr_en & post_trigger_i & (cnt_q == n_q - ONE);

    always_comb begin
        wr_addr_d   = wr_addr_q;
        trig_addr_d = trig_addr_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        wrapped_d   = wrapped_q;
        done_d      = done_q;
        complete_d  = 1'b0;
        cap_valid_d = cap_valid_q;
        if (start_acc) begin
            wr_addr_d   = '0;
            cnt_d       = '0;
            n_d         = ADDR_W'(clamp_one(32'(post_count_i)));
            wrapped_d   = 1'b0;
            done_d      = 1'b0;
            cap_valid_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_addr_d = wr_addr_q + ONE;
                if (wr_addr_q == '1) wrapped_d = 1'b1;
            end
            if (wr_en && post_trigger_i) cnt_d = cnt_q + ONE;
            if (last_post_wr) begin
                done_d      = 1'b1;
                complete_d  = 1'b1;
                cap_valid_d = 1'b1;
            end
        end
        if (post_trigger_i && !post_prev_q) trig_addr_d = wr_addr_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_addr_q   <= '0;
            trig_addr_q <= '0;
            cnt_q       <= '0;
            n_q         <= '0;
            wrapped_q   <= 1'b0;
            done_q      <= 1'b0;
            complete_q  <= 1'b0;
            cap_valid_q <= 1'b0;
            post_prev_q <= 1'b0;
        end else begin
            wr_addr_q   <= wr_addr_d;
            trig_addr_q <= trig_addr_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            wrapped_q   <= wrapped_d;
            done_q      <= done_d;
            complete_q  <= complete_d;
            cap_valid_q <= cap_valid_d;
            post_prev_q <= post_trigger_i;
        end
    end

    assign wr_en_o         = wr_en;
    assign wr_addr_o       = wr_addr_q;
    assign complete_o      = complete_q;
    assign trig_addr_o     = trig_addr_q;
    assign wrapped_o       = wrapped_q;
    assign capture_valid_o = cap_valid_q;

    capture_readout_seq #(
        .ADDR_W(ADDR_W)
    ) u_readout (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .idle_i         (idle_i),
        .capture_valid_i(cap_valid_q),
        .wrapped_i      (wrapped_q),
        .wr_addr_i      (wr_addr_q),
        .rd_start_i     (rd_start_i),
        .rd_next_i      (rd_next_i),
        .rd_addr_o      (rd_addr_o),
        .rd_busy_o      (rd_busy_o),
        .rd_last_o      (rd_last_o)
    );

endmodule

// File: tb/tb_capture_buffer_ctrl.sv
// Directed bench for capture_buffer_ctrl at ADDR_W=4: a vector table for the basic
// capture plus hand sequences for wrap, clamp, strobing, abort and reset cases.
module tb_capture_buffer_ctrl;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset, start, idle, pre, post, sv, rd_start, rd_next;
    logic [AW-1:0] post_count;
    logic          wr_en, complete, wrapped, capture_valid, rd_busy, rd_last;
    logic [AW-1:0] wr_addr, trig_addr, rd_addr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    capture_buffer_ctrl #(.ADDR_W(AW)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .start_i        (start),
        .idle_i         (idle),
        .pre_trigger_i  (pre),
        .post_trigger_i (post),
        .sample_valid_i (sv),
        .post_count_i   (post_count),
        .wr_en_o        (wr_en),
        .wr_addr_o      (wr_addr),
        .complete_o     (complete),
        .trig_addr_o    (trig_addr),
        .wrapped_o      (wrapped),
        .capture_valid_o(capture_valid),
        .rd_start_i     (rd_start),
        .rd_next_i      (rd_next),
        .rd_addr_o      (rd_addr),
        .rd_busy_o      (rd_busy),
        .rd_last_o      (rd_last)
    );

    typedef struct {
        logic st, idl, pr, po, s;
        logic e_wr;
        int   e_addr;
        logic e_cmp;
        int   e_trig;
        logic e_wrap, e_cv;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        start = 0; idle = 1; pre = 0; post = 0; sv = 0; rd_start = 0; rd_next = 0;
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        chk({tag, " wr_en"}, wr_en, 0);
        chk({tag, " wr_addr"}, wr_addr, 0);
        chk({tag, " complete"}, complete, 0);
        chk({tag, " trig_addr"}, trig_addr, 0);
        chk({tag, " wrapped"}, wrapped, 0);
        chk({tag, " capture_valid"}, capture_valid, 0);
        chk({tag, " rd_addr"}, rd_addr, 0);
        chk({tag, " rd_busy"}, rd_busy, 0);
        chk({tag, " rd_last"}, rd_last, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_readout(input int first, input int count);
        rd_start = 1;
        step();
        rd_start = 0;
        for (int i = 0; i < count; i++) begin
            rd_next = 1;
            @(negedge clk);
            chk("rd_addr", rd_addr, (first + i) % 16);
            chk("rd_busy", rd_busy, 1);
            chk("rd_last", rd_last, (i == count - 1) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        rd_next = 0;
        @(negedge clk);
        chk("rd_busy after last", rd_busy, 0);
        @(posedge clk);
        #1;
    endtask

    // Acts as the capture FSM: start, npre pre strobes, then post-trigger until
    // the expected complete cycle; strobe on every per-th cycle.
    task automatic run_capture(input int n, input int npre, input int per);
        int   ncl, c, pre_cnt, pw, last_c;
        logic exp_wr, exp_cmp;
        ncl = (n == 0) ? 1 : n;
        post_count = AW'(n);
        start = 1; idle = 1;
        step();
        start = 0; idle = 0; pre = 1;
        c = 0; pre_cnt = 0;
        while (pre_cnt < npre) begin
            sv = (c % per == 0);
            @(negedge clk);
            if (c == 0) begin
                chk("start clears wr_addr", wr_addr, 0);
                chk("start clears wrapped", wrapped, 0);
                chk("start clears capture_valid", capture_valid, 0);
            end
            chk("pre wr_en", wr_en, sv);
            if (sv) pre_cnt++;
            @(posedge clk);
            #1;
            c++;
        end
        pre = 0; post = 1; pw = 0; last_c = -10;
        for (int k = 0; k < 200; k++) begin
            sv      = (c % per == 0);
            exp_wr  = sv && (pw < ncl);
            exp_cmp = (pw == ncl) && (c == last_c + 1);
            @(negedge clk);
            chk("post wr_en", wr_en, exp_wr);
            chk("complete", complete, exp_cmp);
            if (exp_wr) begin
                pw++;
                last_c = c;
            end
            @(posedge clk);
            #1;
            c++;
            if (exp_cmp) break;
        end
        post = 0; sv = 0; idle = 1;
        @(negedge clk);
        chk("complete single cycle", complete, 0);
        chk("capture_valid set", capture_valid, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        quiet_inputs();
        post_count = '0;
        reset = 1;
        step();
        step();
        check_all_zero("reset");
        reset = 0;

        // Basic capture, N=4, 3 pre samples, continuous strobe.
        tbl[0]  = '{1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 1,  1, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 0, 1,  1, 1, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 1, 0, 1,  1, 2, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 1, 1,  1, 3, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 1, 1,  1, 4, 0, 3, 0, 0};
        tbl[6]  = '{0, 0, 0, 1, 1,  1, 5, 0, 3, 0, 0};
        tbl[7]  = '{0, 0, 0, 1, 1,  1, 6, 0, 3, 0, 0};
        tbl[8]  = '{0, 0, 0, 1, 1,  0, 7, 1, 3, 0, 1};
        tbl[9]  = '{0, 1, 0, 0, 1,  0, 7, 0, 3, 0, 1};
        tbl[10] = '{0, 1, 0, 0, 0,  0, 7, 0, 3, 0, 1};
        post_count = 4'd4;
        for (int i = 0; i < 11; i++) begin
            start = tbl[i].st; idle = tbl[i].idl; pre = tbl[i].pr;
            post = tbl[i].po;  sv = tbl[i].s;
            @(negedge clk);
            chk($sformatf("v%0d wr_en", i), wr_en, tbl[i].e_wr);
            chk($sformatf("v%0d wr_addr", i), wr_addr, tbl[i].e_addr);
            chk($sformatf("v%0d complete", i), complete, tbl[i].e_cmp);
            chk($sformatf("v%0d trig_addr", i), trig_addr, tbl[i].e_trig);
            chk($sformatf("v%0d wrapped", i), wrapped, tbl[i].e_wrap);
            chk($sformatf("v%0d capture_valid", i), capture_valid, tbl[i].e_cv);
            @(posedge clk);
            #1;
        end
        quiet_inputs();
        do_readout(0, 7);

        // Wrapped capture: N=5 after 20 pre samples.
        run_capture(5, 20, 1);
        chk("wrap wrapped", wrapped, 1);
        chk("wrap trig_addr", trig_addr, 4);
        chk("wrap wr_addr", wr_addr, 9);
        do_readout(9, 16);

        // start during readout drops back to idle.
        rd_start = 1;
        step();
        rd_start = 0; rd_next = 1;
        step();
        rd_next = 0; start = 1; post_count = 4'd1;
        @(negedge clk);
        chk("readout running before start", rd_busy, 1);
        chk("readout addr advanced", rd_addr, 10);
        @(posedge clk);
        #1;
        start = 0;
        @(negedge clk);
        chk("start aborts readout", rd_busy, 0);
        chk("start clears capture_valid", capture_valid, 0);
        @(posedge clk);
        #1;

        // post_count=0 clamps to a single post-trigger write.
        run_capture(0, 2, 1);
        chk("clamp trig_addr", trig_addr, 2);
        chk("clamp wr_addr", wr_addr, 3);

        // Strobe every 3rd cycle, N=2.
        run_capture(2, 2, 3);
        chk("strobe trig_addr", trig_addr, 2);
        chk("strobe wr_addr", wr_addr, 4);
        chk("strobe wrapped", wrapped, 0);

        // Abort after 5 pre samples.
        post_count = 4'd4; start = 1; idle = 1;
        step();
        start = 0; idle = 0; pre = 1; sv = 1;
        repeat (5) step();
        pre = 0; idle = 1;
        @(negedge clk);
        chk("abort wr_en", wr_en, 0);
        chk("abort wr_addr", wr_addr, 5);
        chk("abort capture_valid", capture_valid, 0);
        @(posedge clk);
        #1;
        sv = 0; rd_start = 1;
        step();
        rd_start = 0;
        @(negedge clk);
        chk("abort rd_busy", rd_busy, 0);
        chk("abort complete", complete, 0);
        @(posedge clk);
        #1;

        // Reset during post-trigger sampling.
        post_count = 4'd8; start = 1; idle = 1;
        step();
        start = 0; idle = 0; pre = 1; sv = 1;
        repeat (3) step();
        pre = 0; post = 1;
        repeat (2) step();
        reset = 1;
        quiet_inputs();
        step();
        reset = 0;
        check_all_zero("reset mid post");
        run_capture(3, 2, 1);
        chk("after reset trig_addr", trig_addr, 2);
        chk("after reset wr_addr", wr_addr, 5);

        // Reset during readout.
        rd_start = 1;
        step();
        rd_start = 0; rd_next = 1;
        step();
        step();
        rd_next = 0;
        @(negedge clk);
        chk("mid readout addr", rd_addr, 2);
        @(posedge clk);
        #1;
        reset = 1;
        step();
        reset = 0;
        check_all_zero("reset mid readout");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
